// File: rtl/multi_comp_pipe.sv
// Multi-channel registered comparator: 2-stage valid-qualified pipeline with
// per-channel match bits, any/all summaries and saturating match counters.
module multi_comp_pipe #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] a,
  input  logic [CHANNELS*WIDTH-1:0] b,
  input  logic [1:0]                mode,
  input  logic                      signed_en,
  input  logic                      clr_cnt,
  input  logic [SEL_W-1:0]          cnt_sel,
  output logic                      out_valid,
  output logic [CHANNELS-1:0]       match,
  output logic                      x,
  output logic                      y,
  output logic [CNT_W-1:0]          cnt_out,
  output logic                      sat
);

  localparam int unsigned BUS_W = CHANNELS * WIDTH;

  localparam logic [1:0] MODE_EQ = 2'b00;
  localparam logic [1:0] MODE_LT = 2'b01;
  localparam logic [1:0] MODE_GT = 2'b10;

  // Flipping the sign bit of both operands maps two's-complement order onto
  // unsigned order; equality is unaffected, so EQ/NE need no special case.
  localparam logic [WIDTH-1:0] SIGN_MSK = WIDTH'(1) << (WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Stage 1 operand capture
  logic               s1_valid_q, s1_valid_d;
  logic [BUS_W-1:0]   s1_a_q, s1_a_d;
  logic [BUS_W-1:0]   s1_b_q, s1_b_d;
  logic [1:0]         s1_mode_q, s1_mode_d;
  logic               s1_signed_q, s1_signed_d;

  // Stage 2 results and counters
  logic                out_valid_q, out_valid_d;
  logic [CHANNELS-1:0] match_q, match_d;
  logic                x_q, x_d;
  logic                y_q, y_d;
  logic                sat_q, sat_d;
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];

  logic [CHANNELS-1:0] cmp_c;

  // Per-channel compare of the stage-1 operands
  always_comb begin
    logic [WIDTH-1:0] av;
    logic [WIDTH-1:0] bv;
    cmp_c = '0;
    av    = '0;
    bv    = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      av = s1_a_q[i*WIDTH +: WIDTH] ^ (s1_signed_q ? SIGN_MSK : '0);
      bv = s1_b_q[i*WIDTH +: WIDTH] ^ (s1_signed_q ? SIGN_MSK : '0);
      case (s1_mode_q)
        MODE_EQ: cmp_c[i] = (av == bv);
        MODE_LT: cmp_c[i] = (av <  bv);
        MODE_GT: cmp_c[i] = (av >  bv);
        default: cmp_c[i] = (av != bv);
      endcase
    end
  end

  // Next-state for pipeline, summaries and saturating counters
  always_comb begin
    s1_valid_d  = in_valid;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_mode_d   = s1_mode_q;
    s1_signed_d = s1_signed_q;
    out_valid_d = s1_valid_q;
    match_d     = match_q;
    x_d         = x_q;
    y_d         = y_q;
    sat_d       = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
    end

    if (in_valid) begin
      s1_a_d      = a;
      s1_b_d      = b;
      s1_mode_d   = mode;
      s1_signed_d = signed_en;
    end

    if (s1_valid_q) begin
      match_d = cmp_c;
      x_d     = |cmp_c;
      y_d     = &cmp_c;
    end

    // Clear wins over a same-edge increment
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (clr_cnt) begin
        cnt_d[i] = '0;
      end else if (s1_valid_q && cmp_c[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      sat_d = sat_d | (cnt_d[i] == CNT_MAX);
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_mode_q   <= '0;
      s1_signed_q <= 1'b0;
      out_valid_q <= 1'b0;
      match_q     <= '0;
      x_q         <= 1'b0;
      y_q         <= 1'b0;
      sat_q       <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_mode_q   <= s1_mode_d;
      s1_signed_q <= s1_signed_d;
      out_valid_q <= out_valid_d;
      match_q     <= match_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sat_q       <= sat_d;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Counter read mux; out-of-range selects read zero
  always_comb begin
    cnt_out = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (SEL_W'(i) == cnt_sel) begin
        cnt_out = cnt_q[i];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign match     = match_q;
  assign x         = x_q;
  assign y         = y_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_multi_comp_pipe.sv
// Self-checking bench for multi_comp_pipe: directed scenarios plus random
// traffic compared against a transaction-level reference model.
module tb_multi_comp_pipe;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned CHANNELS = 4;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned SEL_W    = 2;
  localparam int          CMAX     = (1 << CNT_W) - 1;

  logic                      clk;
  logic                      rst_n;
  logic                      in_valid;
  logic [CHANNELS*WIDTH-1:0] a;
  logic [CHANNELS*WIDTH-1:0] b;
  logic [1:0]                mode;
  logic                      signed_en;
  logic                      clr_cnt;
  logic [SEL_W-1:0]          cnt_sel;
  logic                      out_valid;
  logic [CHANNELS-1:0]       match;
  logic                      x;
  logic                      y;
  logic [CNT_W-1:0]          cnt_out;
  logic                      sat;

  multi_comp_pipe #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .CNT_W(CNT_W), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .mode(mode), .signed_en(signed_en), .clr_cnt(clr_cnt), .cnt_sel(cnt_sel),
    .out_valid(out_valid), .match(match), .x(x), .y(y),
    .cnt_out(cnt_out), .sat(sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: one pending transaction and the visible results
  bit          m_pend_v;
  logic [31:0] m_pend_a, m_pend_b;
  logic [1:0]  m_pend_mode;
  bit          m_pend_sgn;
  bit          e_valid, e_x, e_y, e_sat;
  logic [3:0]  e_match;
  int          e_cnt [CHANNELS];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_cmp(input int av, input int bv, input logic [1:0] md, input bit sg);
    int sa, sb;
    sa = av;
    sb = bv;
    if (sg && (md == 2'b01 || md == 2'b10)) begin
      if (sa >= 128) sa -= 256;
      if (sb >= 128) sb -= 256;
    end
    case (md)
      2'b00:   return sa == sb;
      2'b01:   return sa < sb;
      2'b10:   return sa > sb;
      default: return sa != sb;
    endcase
  endfunction

  task automatic m_reset();
    m_pend_v = 0; m_pend_a = '0; m_pend_b = '0; m_pend_mode = '0; m_pend_sgn = 0;
    e_valid = 0; e_x = 0; e_y = 0; e_sat = 0; e_match = '0;
    for (int i = 0; i < CHANNELS; i++) e_cnt[i] = 0;
  endtask

  // Apply one clock edge to the model using the inputs the DUT just sampled
  task automatic m_edge();
    bit r;
    e_valid = m_pend_v;
    if (m_pend_v) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r = ref_cmp(int'((m_pend_a >> (8*i)) & 32'hFF), int'((m_pend_b >> (8*i)) & 32'hFF),
                    m_pend_mode, m_pend_sgn);
        e_match[i] = r;
        if (r && e_cnt[i] < CMAX) e_cnt[i]++;
      end
      e_x = (e_match != 4'h0);
      e_y = (e_match == 4'hF);
    end
    if (clr_cnt) for (int i = 0; i < CHANNELS; i++) e_cnt[i] = 0;
    e_sat = 0;
    for (int i = 0; i < CHANNELS; i++) if (e_cnt[i] == CMAX) e_sat = 1;
    m_pend_v = in_valid;
    if (in_valid) begin
      m_pend_a = a; m_pend_b = b; m_pend_mode = mode; m_pend_sgn = signed_en;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(e_valid));
    chk({tag, ".match"}, 32'(match), 32'(e_match));
    chk({tag, ".x"}, 32'(x), 32'(e_x));
    chk({tag, ".y"}, 32'(y), 32'(e_y));
    chk({tag, ".sat"}, 32'(sat), 32'(e_sat));
    chk({tag, ".cnt"}, 32'(cnt_out), 32'(e_cnt[cnt_sel]));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    m_edge();
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse away from any clock edge
  task automatic pulse_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    chk({tag, ".rst_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".rst_cnt"}, 32'(cnt_out), 32'd0);
    chk({tag, ".rst_sat"}, 32'(sat), 32'd0);
    chk({tag, ".rst_match"}, 32'(match), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; clr_cnt = 0; signed_en = 0; mode = 2'b00;
  endtask

  initial begin
    m_reset();
    rst_n = 1'b0; in_valid = 1; a = 32'hDEADBEEF; b = 32'hDEADBEEF;
    mode = 2'b00; signed_en = 0; clr_cnt = 0; cnt_sel = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.valid", 32'(out_valid), 32'd0);
    chk("reset.match", 32'(match), 32'd0);
    chk("reset.x", 32'(x), 32'd0);
    chk("reset.y", 32'(y), 32'd0);
    chk("reset.cnt", 32'(cnt_out), 32'd0);
    chk("reset.sat", 32'(sat), 32'd0);
    idle_inputs();
    rst_n = 1'b1;
    tick("idle");

    // Latency and EQ vector
    in_valid = 1; a = 32'h051020FF; b = 32'h05112000; mode = 2'b00;
    tick("lat1");
    chk("lat.edge1_valid", 32'(out_valid), 32'd0);
    idle_inputs();
    tick("lat2");
    chk("lat.edge2_valid", 32'(out_valid), 32'd1);
    chk("lat.match", 32'(match), 32'hA);
    chk("lat.x", 32'(x), 32'd1);
    chk("lat.y", 32'(y), 32'd0);
    tick("lat3");

    // Signed vs unsigned LT back-to-back
    in_valid = 1; a = 32'h00000080; b = 32'h00000001; mode = 2'b01; signed_en = 0;
    tick("sgn1");
    signed_en = 1;
    tick("sgn2");
    chk("sgn.unsigned_m0", 32'(match[0]), 32'd0);
    chk("sgn.valid1", 32'(out_valid), 32'd1);
    idle_inputs();
    tick("sgn3");
    chk("sgn.signed_m0", 32'(match[0]), 32'd1);
    chk("sgn.valid2", 32'(out_valid), 32'd1);
    tick("sgn4");

    // All-match EQ then NE
    in_valid = 1; a = 32'h3C3C3C3C; b = 32'h3C3C3C3C; mode = 2'b00;
    tick("all1");
    mode = 2'b11;
    tick("all2");
    chk("all.eq_match", 32'(match), 32'hF);
    chk("all.eq_y", 32'(y), 32'd1);
    idle_inputs();
    tick("all3");
    chk("all.ne_match", 32'(match), 32'h0);
    chk("all.ne_x", 32'(x), 32'd0);
    tick("all4");

    // Counter saturation on channel 2, then clear coincident with a match
    clr_cnt = 1; tick("satclr"); clr_cnt = 0;
    cnt_sel = 2'd2; a = 32'h00550000; b = 32'h00550000; mode = 2'b00; in_valid = 1;
    for (int k = 0; k <= 10; k++) begin
      if (k == 10) in_valid = 0;
      tick("sat");
      if (k >= 1) begin
        chk("sat.count", 32'(cnt_out), 32'((k < CMAX) ? k : CMAX));
        chk("sat.flag", 32'(sat), 32'(k >= CMAX));
      end
    end
    in_valid = 1; tick("satm1");
    in_valid = 0; clr_cnt = 1; tick("satm2");
    chk("sat.clr_cnt", 32'(cnt_out), 32'd0);
    chk("sat.clr_flag", 32'(sat), 32'd0);
    clr_cnt = 0;
    tick("satm3");

    // Accumulate some count, then reset mid-stream
    in_valid = 1; a = 32'h11223344; b = 32'h11223344; mode = 2'b00;
    tick("rs1");
    tick("rs2");
    pulse_reset("rs");
    tick("rs3");
    chk("rs.after_valid", 32'(out_valid), 32'd0);
    tick("rs4");
    chk("rs.fresh_valid", 32'(out_valid), 32'd1);
    idle_inputs();
    tick("rs5");

    // Bubble: 1,0,1 with different data so hold is observable
    in_valid = 1; a = 32'h01020304; b = 32'h01FF03FF; mode = 2'b00;
    tick("bub1");
    in_valid = 0; a = 32'hFFFFFFFF; b = 32'h0; mode = 2'b11;
    tick("bub2");
    chk("bub.v1", 32'(out_valid), 32'd1);
    chk("bub.m1", 32'(match), 32'hA);
    in_valid = 1; a = 32'h0; b = 32'h0; mode = 2'b00;
    tick("bub3");
    chk("bub.v0", 32'(out_valid), 32'd0);
    chk("bub.hold", 32'(match), 32'hA);
    idle_inputs();
    tick("bub4");
    chk("bub.v2", 32'(out_valid), 32'd1);
    chk("bub.m2", 32'(match), 32'hF);
    tick("bub5");

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      a         = $urandom;
      b         = $urandom;
      for (int c = 0; c < CHANNELS; c++)
        if ($urandom_range(0, 2) == 0) b[c*8 +: 8] = a[c*8 +: 8];
      mode      = 2'($urandom_range(0, 3));
      signed_en = 1'($urandom_range(0, 1));
      clr_cnt   = ($urandom_range(0, 29) == 0);
      cnt_sel   = SEL_W'($urandom_range(0, CHANNELS - 1));
      tick("rnd");
      if ($urandom_range(0, 399) == 0) pulse_reset("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
